mem_rdata_cancel_ctrl: RTL
==========================

Name: mem_rdata_cancel_ctrl

Overview:
- Sequences read requests from the MEM pipeline stage onto the SRAM-like data bus (addr_ok / data_ok handshake).
- Tracks up to MAX_OUT in-flight requests and buffers returned data in a small FIFO until the pipeline accepts it.
- On an exception flush, marks every in-flight request as cancelled and silently drops its late data_ok return. This replaces ad-hoc clear-count FSMs in the stage registers.

Parameters:
- DATA_W, 32, width of returned read data.
- MAX_OUT, 2, maximum in-flight requests plus buffered responses (credit limit); counters are 2 bits wide.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush_i  input  1  exception/ertn flush; cancels all in-flight and buffered reads.
- req_i  input  1  stage wants to issue a read.
- req_accept_o  output  1  request handshaken this cycle (bus_req_o & bus_addr_ok_i).
- bus_req_o  output  1  request to bus.
- bus_addr_ok_i  input  1  bus accepted the address.
- bus_data_ok_i  input  1  bus returns read data.
- bus_rdata_i  input  DATA_W  returned data.
- resp_valid_o  output  1  buffered response available.
- resp_data_o  output  DATA_W  head-of-FIFO data.
- resp_ready_i  input  1  pipeline consumes the response (stage allowin).
- outstanding_o  output  2  in-flight request count (oc).
- cancel_cnt_o  output  2  pending discards (cc); 0 = Normal, 1 = Cancel1, 2 = Cancel2.
- bus_err_o  output  1  sticky protocol error flag.

Behaviour:
- Reset (async, rst_n=0):
  - oc=0, cc=0, FIFO empty, bus_err_o=0.
  - All outputs 0; resp_data_o=0.
- Credit rule:
  - bus_req_o = req_i & ~flush_i & (oc + fifo_cnt < MAX_OUT).
  - The FIFO therefore never overflows.
- Issue: bus_req_o & bus_addr_ok_i increments oc.
- Return handling (bus_data_ok_i=1, oc>0):
  - oc decrements.
  - If flush_i=1 or cc>0, the data is dropped. cc decrements only when cc>0 and flush_i=0.
  - Otherwise the data is pushed into the FIFO.
  - Simultaneous issue and return in one cycle: oc is unchanged.
- FIFO:
  - Depth MAX_OUT, first-word-fall-through from registers.
  - resp_valid_o = (fifo_cnt != 0).
  - Pop on resp_valid_o & resp_ready_i.
  - Push and pop in the same cycle are legal; count is unchanged and order is preserved.
  - Latency from data_ok to resp_valid_o is exactly 1 cycle; there is no combinational bypass.
- Flush (flush_i=1):
  - No issue that cycle.
  - FIFO cleared next edge; resp_valid_o=0 the following cycle.
  - cc_next = oc - bus_data_ok_i, i.e. every request still outstanding after this edge is cancelled.
  - oc_next = oc - bus_data_ok_i.
  - A flush during Cancel1/Cancel2 recomputes cc by the same rule; it never accumulates.
- Cancel FSM (state = cc):
  - Normal→Cancel1 or Cancel2 on flush with 1 or 2 left in flight.
  - Cancel2→Cancel1 on a dropped return.
  - Cancel1→Normal on a dropped return.
  - New requests may issue in Cancel states within the credit limit. Their returns arrive after the cancelled ones (in-order bus) and are kept.
- Invariant: cc <= oc at all times.
- Protocol error: bus_data_ok_i with oc=0 and no flush sets bus_err_o, which holds until reset. The data is ignored and counters do not change.
- bus_addr_ok_i while bus_req_o=0 is ignored.

Test Plan:
- Single read: req_i=1, addr_ok in cycle 0, data_ok with 0x1234_5678 in cycle 3, resp_ready_i=1 → resp_valid_o=1 with 0x1234_5678 in cycle 4; oc returns to 0.
- Credit stall: two requests issued, resp_ready_i=0, both data_ok return → fifo_cnt=2, bus_req_o=0 despite req_i=1. One pop → bus_req_o=1 again. Data pops in order A then B.
- Flush with 2 in flight: oc=2, flush_i pulse → cc=2, FIFO empty. The next two data_ok (0xAAAA0000, 0xBBBB0000) are dropped, with cc 2→1→0 and resp_valid_o staying 0. A new request issued in Cancel1 returns 0xCCCC0000, which is delivered.
- Flush coinciding with data_ok: oc=2, flush_i and data_ok in the same cycle → oc=1, cc=1, no FIFO push. The next return is dropped.
- Protocol error and reset: data_ok with oc=0 → bus_err_o=1, oc stays 0. Asserting rst_n=0 mid-operation with oc=2, cc=1 and fifo_cnt=1 clears everything immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mem_rdata_cancel_ctrl.sv
// Read-request sequencer for the MEM stage: credit-limited issue onto the
// addr_ok/data_ok bus, FWFT response FIFO, and cancellation of in-flight reads on flush.
module mem_rdata_cancel_ctrl #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MAX_OUT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              req_i,
  output logic              req_accept_o,
  output logic              bus_req_o,
  input  logic              bus_addr_ok_i,
  input  logic              bus_data_ok_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic              resp_valid_o,
  output logic [DATA_W-1:0] resp_data_o,
  input  logic              resp_ready_i,
  output logic [1:0]        outstanding_o,
  output logic [1:0]        cancel_cnt_o,
  output logic              bus_err_o
);

  localparam int unsigned PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    CANCEL1 = 2'd1,
    CANCEL2 = 2'd2
  } cancel_state_e;

  cancel_state_e     state_q, state_d;
  logic [1:0]        oc_q, oc_d, oc_after_ret;
  logic [1:0]        fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [DATA_W-1:0] mem_q [MAX_OUT];
  logic              err_q;

  logic [2:0] credit_used;
  logic       can_issue;
  logic       issue;
  logic       ret;
  logic       drop;
  logic       push;
  logic       pop;
  logic       proto_err;
  logic       in_cancel;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + 1'b1;
  endfunction

  // Buffered responses count against the credit so the FIFO can never overflow.
  assign credit_used  = {1'b0, oc_q} + {1'b0, fifo_cnt_q};
  assign can_issue    = (credit_used < 3'(MAX_OUT));
  assign bus_req_o    = req_i & ~flush_i & can_issue;
  assign issue        = bus_req_o & bus_addr_ok_i;
  assign req_accept_o = issue;

  assign ret          = bus_data_ok_i & (oc_q != 2'd0);
  assign proto_err    = bus_data_ok_i & (oc_q == 2'd0) & ~flush_i;
  assign drop         = ret & (flush_i | in_cancel);
  assign push         = ret & ~drop;
  assign pop          = resp_valid_o & resp_ready_i & ~flush_i;

  assign oc_after_ret = oc_q - {1'b0, ret};
  assign oc_d         = oc_after_ret + {1'b0, issue};
  assign fifo_cnt_d   = fifo_cnt_q + {1'b0, push} - {1'b0, pop};

  // Cancel FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= NORMAL;
    end else begin
      state_q <= state_d;
    end
  end

  // Cancel FSM: next state. A flush recomputes the discard count from scratch.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      case (oc_after_ret)
        2'd0:    state_d = NORMAL;
        2'd1:    state_d = CANCEL1;
        default: state_d = CANCEL2;
      endcase
    end else if (drop) begin
      case (state_q)
        CANCEL2: state_d = CANCEL1;
        CANCEL1: state_d = NORMAL;
        default: state_d = state_q;
      endcase
    end
  end

  // Cancel FSM: outputs
  always_comb begin
    cancel_cnt_o = 2'(state_q);
    in_cancel    = (state_q != NORMAL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oc_q  <= '0;
      err_q <= 1'b0;
    end else begin
      oc_q <= oc_d;
      if (proto_err) begin
        err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_cnt_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else if (flush_i) begin
      fifo_cnt_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fifo_cnt_q <= fifo_cnt_d;
      if (push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MAX_OUT; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= bus_rdata_i;
    end
  end

  assign resp_valid_o  = (fifo_cnt_q != 2'd0);
  assign resp_data_o   = mem_q[rd_ptr_q];
  assign outstanding_o = oc_q;
  assign bus_err_o     = err_q;

endmodule
